// File: rtl/hub75_capture.sv
// HUB75 receive-side monitor: oversamples the panel bus, rebuilds each latched row pair
// in a ping-pong buffer and replays it as (row, col, rgb) valid/ready beats.
module hub75_capture #(
    parameter int NUM_COLS    = 64,
    parameter int NUM_ROWS    = 64,
    parameter int SCAN_RATE   = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         hub_clk,
    input  logic                         hub_latch,
    input  logic [$clog2(SCAN_RATE)-1:0] hub_addr,
    input  logic [2:0]                   hub_rgb0,
    input  logic [2:0]                   hub_rgb1,
    output logic                         px_valid,
    input  logic                         px_ready,
    output logic [$clog2(NUM_ROWS)-1:0]  px_row,
    output logic [$clog2(NUM_COLS)-1:0]  px_col,
    output logic [2:0]                   px_rgb,
    output logic                         px_last,
    output logic                         frame_start,
    output logic [7:0]                   len_err_count,
    output logic [7:0]                   drop_count,
    output logic [1:0]                   dbg_state
);
    localparam int AW = $clog2(SCAN_RATE);
    localparam int RW = $clog2(NUM_ROWS);
    localparam int CW = $clog2(NUM_COLS);
    localparam int PW = $clog2(NUM_COLS + 2);
    localparam int SW = AW + 8;

    // Handshake: a beat transfers on any rising clk_in edge where px_valid & px_ready are both
    // high; while px_valid is high and px_ready low, row/col/rgb/last stay unchanged.

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TOP  = 2'd1,
        ST_BOT  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [PW-1:0]   pcnt_q, pcnt_d;
    logic            fill_sel_q;
    logic            prev_clk_q, prev_latch_q;
    logic            frame_q;
    logic [7:0]      len_err_q, drop_q;
    logic [SW-1:0]   sync_q [SYNC_STAGES];
    logic [5:0]      buf_q [2][NUM_COLS];

    logic [SW-1:0]   s_bus;
    logic            s_clk, s_latch;
    logic [AW-1:0]   s_addr;
    logic [5:0]      s_pix;
    logic            clk_rise, latch_rise, cnt_inc, wr_en;
    logic            row_ok, accept, drop, len_bad, rd_sel;
    logic [PW-1:0]   pcnt_eff;
    logic [5:0]      rd_word;

    assign s_bus   = sync_q[SYNC_STAGES-1];
    assign s_clk   = s_bus[SW-1];
    assign s_latch = s_bus[SW-2];
    assign s_addr  = s_bus[SW-3 -: AW];
    assign s_pix   = s_bus[5:0];

    // A pixel shifted in the same cycle as the latch edge still belongs to the closing row.
    assign clk_rise   = s_clk & ~prev_clk_q;
    assign latch_rise = s_latch & ~prev_latch_q;
    assign cnt_inc    = clk_rise && (pcnt_q != PW'(NUM_COLS + 1));
    assign pcnt_eff   = pcnt_q + PW'(cnt_inc);
    assign wr_en      = clk_rise && (pcnt_q < PW'(NUM_COLS));
    assign row_ok     = latch_rise && (pcnt_eff == PW'(NUM_COLS));
    assign accept     = row_ok && (state_q == ST_IDLE);
    assign drop       = row_ok && (state_q != ST_IDLE);
    assign len_bad    = latch_rise && (pcnt_eff != PW'(NUM_COLS));
    assign rd_sel     = ~fill_sel_q;
    assign rd_word    = buf_q[rd_sel][col_q];

    always_comb begin
        pcnt_d = pcnt_q;
        if (latch_rise) begin
            pcnt_d = '0;
        end else if (cnt_inc) begin
            pcnt_d = pcnt_q + PW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        addr_d  = addr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_TOP;
                    col_d   = '0;
                    addr_d  = s_addr;
                end
            end
            ST_TOP: begin
                if (px_ready) begin
                    col_d = col_q + CW'(1);
                    if (col_q == CW'(NUM_COLS - 1)) begin
                        state_d = ST_BOT;
                        col_d   = '0;
                    end
                end
            end
            ST_BOT: begin
                if (px_ready) begin
                    col_d = col_q + CW'(1);
                    if (col_q == CW'(NUM_COLS - 1)) begin
                        state_d = ST_IDLE;
                        col_d   = '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        px_valid = 1'b0;
        px_row   = '0;
        px_col   = '0;
        px_rgb   = '0;
        px_last  = 1'b0;
        unique case (state_q)
            ST_TOP: begin
                px_valid = 1'b1;
                px_row   = RW'(addr_q);
                px_col   = col_q;
                px_rgb   = rd_word[2:0];
            end
            ST_BOT: begin
                px_valid = 1'b1;
                px_row   = RW'(addr_q) + RW'(SCAN_RATE);
                px_col   = col_q;
                px_rgb   = rd_word[5:3];
                px_last  = (col_q == CW'(NUM_COLS - 1));
            end
            default: ;
        endcase
    end

    assign frame_start   = frame_q;
    assign len_err_count = len_err_q;
    assign drop_count    = drop_q;
    assign dbg_state     = state_q;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            state_q      <= ST_IDLE;
            col_q        <= '0;
            addr_q       <= '0;
            pcnt_q       <= '0;
            fill_sel_q   <= 1'b0;
            prev_clk_q   <= 1'b0;
            prev_latch_q <= 1'b0;
            frame_q      <= 1'b0;
            len_err_q    <= '0;
            drop_q       <= '0;
        end else begin
            sync_q[0] <= {hub_clk, hub_latch, hub_addr, hub_rgb1, hub_rgb0};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            state_q      <= state_d;
            col_q        <= col_d;
            addr_q       <= addr_d;
            pcnt_q       <= pcnt_d;
            prev_clk_q   <= s_clk;
            prev_latch_q <= s_latch;
            frame_q      <= accept && (s_addr == '0);
            if (accept) fill_sel_q <= ~fill_sel_q;
            if (len_bad && len_err_q != 8'hFF) len_err_q <= len_err_q + 8'd1;
            if (drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
        end
    end

    // Pixel storage needs no reset; only rows that were fully shifted are ever read.
    always_ff @(posedge clk_in) begin
        if (wr_en) buf_q[fill_sel_q][pcnt_q[CW-1:0]] <= s_pix;
    end
endmodule

// File: tb/tb_hub75_capture.sv
// Bench for hub75_capture: drives HUB75 rows through directed scenarios and scoreboards
// every pixel beat against a row-level model of the capture rules.
module tb_hub75_capture;
    localparam int NC = 64;
    localparam int NR = 64;
    localparam int SR = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       hub_clk = 1'b0, hub_latch = 1'b0;
    logic [4:0] hub_addr = '0;
    logic [2:0] hub_rgb0 = '0, hub_rgb1 = '0;
    logic       px_ready = 1'b1;
    logic       px_valid, px_last, frame_start;
    logic [5:0] px_row, px_col;
    logic [2:0] px_rgb;
    logic [7:0] len_err_count, drop_count;
    logic [1:0] dbg_state;
    logic [15:0] beat;

    always #5 clk = ~clk;

    hub75_capture #(.NUM_COLS(NC), .NUM_ROWS(NR), .SCAN_RATE(SR), .SYNC_STAGES(2)) dut (
        .clk_in(clk), .rst_in(rst_n), .hub_clk(hub_clk), .hub_latch(hub_latch),
        .hub_addr(hub_addr), .hub_rgb0(hub_rgb0), .hub_rgb1(hub_rgb1),
        .px_valid(px_valid), .px_ready(px_ready), .px_row(px_row), .px_col(px_col),
        .px_rgb(px_rgb), .px_last(px_last), .frame_start(frame_start),
        .len_err_count(len_err_count), .drop_count(drop_count), .dbg_state(dbg_state)
    );

    assign beat = {px_last, px_row, px_col, px_rgb};

    int n_tests = 0, n_fail = 0;
    logic [15:0] exp_q[$];
    logic [15:0] act_log[$];
    int beats_acc = 0, frames_seen = 0, exp_frames = 0, exp_len = 0, exp_drop = 0;
    int ready_mode = 0;

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] pix0(int pat, int c);
        int v;
        v = c + pat * 3;
        return v[2:0];
    endfunction

    function automatic logic [2:0] pix1(int pat, int c);
        int v;
        v = c + pat * 5;
        return ~v[2:0];
    endfunction

    // Row-level model: a full row is replayed only if nothing is still pending, else counted lost.
    task automatic model_latch(int addr, int npix, int pat);
        if (npix == NC) begin
            if (exp_q.size() == 0) begin
                for (int c = 0; c < NC; c++) exp_q.push_back({1'b0, 6'(addr), 6'(c), pix0(pat, c)});
                for (int c = 0; c < NC; c++) exp_q.push_back({(c == NC - 1), 6'(addr + SR), 6'(c), pix1(pat, c)});
                if (addr == 0) exp_frames++;
            end else if (exp_drop < 255) begin
                exp_drop++;
            end
        end else if (exp_len < 255) begin
            exp_len++;
        end
    endtask

    task automatic pulse(logic [2:0] r0, logic [2:0] r1);
        hub_rgb0 = r0;
        hub_rgb1 = r1;
        tick(2);
        hub_clk = 1'b1;
        tick(2);
        hub_clk = 1'b0;
    endtask

    task automatic send_row(int addr, int npix, int pat);
        for (int c = 0; c < npix; c++) pulse(pix0(pat, c), pix1(pat, c));
        hub_addr = 5'(addr);
        tick(2);
        model_latch(addr, npix, pat);
        hub_latch = 1'b1;
        tick(2);
        hub_latch = 1'b0;
        tick(2);
    endtask

    task automatic wait_drain(string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            tick();
            n++;
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d beats left, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        tick(2);
        check({name, "_idle"}, 32'(px_valid), 32'd0);
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0: px_ready = 1'b1;
            1: px_ready = ~px_ready;
            default: px_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (px_valid) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL beat_unexpected: got %h expected none", beat);
                end else if (beat !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL beat: got %h expected %h", beat, exp_q[0]);
                end
                if (px_ready) begin
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    act_log.push_back(beat);
                    beats_acc++;
                end
            end
            if (frame_start) begin
                frames_seen++;
                n_tests++;
                if (!(px_valid && px_row == 6'd0 && px_col == 6'd0)) begin
                    n_fail++;
                    $display("FAIL frame_start_pos: got valid=%0b row=%0d col=%0d expected 1/0/0",
                             px_valid, px_row, px_col);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, f0, n;
        tick(3);
        check("rst_valid", 32'(px_valid), 32'd0);
        check("rst_last", 32'(px_last), 32'd0);
        check("rst_frame", 32'(frame_start), 32'd0);
        check("rst_rowcolrgb", 32'({px_row, px_col, px_rgb}), 32'd0);
        check("rst_len_err", 32'(len_err_count), 32'd0);
        check("rst_drop", 32'(drop_count), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // 1: plain row, addr 5
        send_row(5, NC, 0);
        wait_drain("t1");
        check("t1_nbeats", 32'(act_log.size()), 32'd128);
        check("t1_beat0", 32'(act_log[0]), 32'({1'b0, 6'd5, 6'd0, 3'd0}));
        check("t1_beat10", 32'(act_log[10]), 32'({1'b0, 6'd5, 6'd10, 3'd2}));
        check("t1_beat64", 32'(act_log[64]), 32'({1'b0, 6'd37, 6'd0, 3'b111}));
        check("t1_beat127", 32'(act_log[127]), 32'({1'b1, 6'd37, 6'd63, 3'b000}));

        // 2: same row with toggling ready
        ready_mode = 1;
        base = act_log.size();
        send_row(5, NC, 0);
        wait_drain("t2");
        ready_mode = 0;
        check("t2_nbeats", 32'(act_log.size() - base), 32'd128);
        check("t2_last_beat", 32'(act_log[act_log.size() - 1]), 32'({1'b1, 6'd37, 6'd63, 3'b000}));

        // 3: short and long rows
        base = act_log.size();
        send_row(6, NC - 1, 1);
        send_row(6, NC + 1, 1);
        tick(4);
        check("t3_no_beats", 32'(act_log.size() - base), 32'd0);
        check("t3_valid", 32'(px_valid), 32'd0);
        check("t3_len_err_model", 32'(len_err_count), 32'(exp_len));
        check("t3_len_err", 32'(len_err_count), 32'd2);

        // 4: two good rows while stalled
        ready_mode = 2;
        tick(2);
        send_row(8, NC, 2);
        send_row(9, NC, 3);
        check("t4_held_valid", 32'(px_valid), 32'd1);
        check("t4_held_pos", 32'({px_row, px_col}), 32'({6'd8, 6'd0}));
        check("t4_drop", 32'(drop_count), 32'd1);
        check("t4_drop_model", 32'(drop_count), 32'(exp_drop));
        ready_mode = 0;
        wait_drain("t4");

        // 5: frame start on addr 0
        f0 = frames_seen;
        send_row(31, NC, 4);
        wait_drain("t5a");
        check("t5_no_frame_31", 32'(frames_seen - f0), 32'd0);
        send_row(0, NC, 5);
        wait_drain("t5b");
        check("t5_frames", 32'(frames_seen - f0), 32'd1);

        // 6: reset mid-drain
        base = beats_acc;
        send_row(9, NC, 6);
        n = 0;
        while (beats_acc < base + 40 && n < 1000) begin
            tick();
            n++;
        end
        check("t6_reach_beat40", 32'(beats_acc >= base + 40), 32'd1);
        rst_n = 1'b0;
        exp_q.delete();
        exp_len = 0;
        exp_drop = 0;
        tick();
        check("t6_valid", 32'(px_valid), 32'd0);
        check("t6_len_err", 32'(len_err_count), 32'd0);
        check("t6_drop", 32'(drop_count), 32'd0);
        check("t6_state", 32'(dbg_state), 32'd0);
        rst_n = 1'b1;
        tick(2);
        base = act_log.size();
        send_row(10, NC, 7);
        wait_drain("t6");
        check("t6_nbeats", 32'(act_log.size() - base), 32'd128);
        check("t6_counters", 32'({len_err_count, drop_count}), 32'({8'(exp_len), 8'(exp_drop)}));

        check("frames_total", 32'(frames_seen), 32'(exp_frames));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
